// File: rtl/prbs_err_checker_pkg.sv
// Shared definitions for the PRBS error checker: pattern selects, LFSR polynomial tables
// and the checker FSM state type.
package prbs_err_checker_pkg;

  localparam logic [2:0] PRBS7  = 3'd0;
  localparam logic [2:0] PRBS9  = 3'd1;
  localparam logic [2:0] PRBS15 = 3'd2;
  localparam logic [2:0] PRBS23 = 3'd3;
  localparam logic [2:0] PRBS31 = 3'd4;

  // History holds the 31 most recent bits; index k is the bit k+1 positions back in time.
  localparam int HIST_W = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } chk_state_e;

  // tap_a/tap_b are history indices of the two feedback bits (polynomial exponent - 1).
  typedef struct packed {
    logic [4:0] order;
    logic [4:0] tap_a;
    logic [4:0] tap_b;
  } prbs_poly_t;

  function automatic prbs_poly_t prbs_poly(input logic [2:0] sel);
    prbs_poly_t p;
    case (sel)
      PRBS7:   p = '{order: 5'd7,  tap_a: 5'd6,  tap_b: 5'd5};
      PRBS9:   p = '{order: 5'd9,  tap_a: 5'd8,  tap_b: 5'd4};
      PRBS15:  p = '{order: 5'd15, tap_a: 5'd14, tap_b: 5'd13};
      PRBS23:  p = '{order: 5'd23, tap_a: 5'd22, tap_b: 5'd17};
      PRBS31:  p = '{order: 5'd31, tap_a: 5'd30, tap_b: 5'd27};
      default: p = '{order: 5'd7,  tap_a: 5'd6,  tap_b: 5'd5};
    endcase
    return p;
  endfunction

  function automatic logic sel_valid(input logic [2:0] sel);
    return sel <= PRBS31;
  endfunction

  // Keeps only the newest 'order' bits of a seed word.
  function automatic logic [HIST_W-1:0] order_mask(input logic [2:0] sel);
    prbs_poly_t p;
    p = prbs_poly(sel);
    return (HIST_W'(1) << p.order) - HIST_W'(1);
  endfunction

endpackage

// File: rtl/prbs_err_checker_if.sv
// Received word stream into the PRBS checker: one word per cycle while rx_valid is high.
interface prbs_err_checker_if #(
  parameter int DATA_W = 32
) ();
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/prbs_err_checker_predict.sv
// prbs_par_predict: unrolls the selected LFSR DATA_W steps from the history to give the
// expected word (earliest bit at the MSB) and the history after that word.
module prbs_par_predict
  import prbs_err_checker_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        sel,
  input  logic [HIST_W-1:0] hist,
  output logic [DATA_W-1:0] pred_word,
  output logic [HIST_W-1:0] next_hist
);

  prbs_poly_t        poly;
  logic [HIST_W-1:0] h;
  logic              nb;

  // NOTE: blocking '=' is correct here: h and nb are running temporaries of one evaluation,
  // and every output gets a default first so no latch is inferred.
  always_comb begin
    poly      = prbs_poly(sel);
    h         = hist;
    nb        = 1'b0;
    pred_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      nb                   = h[poly.tap_a] ^ h[poly.tap_b];
      pred_word[DATA_W-1-i] = nb;
      h                    = {h[HIST_W-2:0], nb};
    end
    next_hist = h;
  end

endmodule

// File: rtl/prbs_err_checker.sv
// Self-synchronising receive PRBS checker with saturating bit/error counters.
// Optional PRBS_CHK_INVERT_EN adds a pattern_inv input for inverted patterns.
module prbs_err_checker
  import prbs_err_checker_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 48,
  parameter int LOCK_WORDS   = 16,
  parameter int UNLOCK_WORDS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              channel_reset,
  input  logic [2:0]        datawidth,
`ifdef PRBS_CHK_INVERT_EN
  input  logic              pattern_inv,
`endif
  prbs_err_checker_if.slave rx,
  output logic              locked,
  output logic              sel_invalid,
  output logic              word_err,
  output logic [CNT_W-1:0]  bit_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
  localparam int BAD_W  = $clog2(UNLOCK_WORDS + 1);
  localparam int ERR_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e        state, state_nxt;
  logic [HIST_W-1:0] hist, hist_nxt, pred_hist, seed;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [BAD_W-1:0]  bad_cnt, bad_nxt;
  logic [2:0]        sel_q;
  logic              inv, inv_q, sel_change, count_word;
  logic [DATA_W-1:0] pred_word, rx_plain, diff;
  logic [ERR_W-1:0]  err_bits;

`ifdef PRBS_CHK_INVERT_EN
  assign inv = pattern_inv;
`else
  assign inv = 1'b0;
`endif

  // History always tracks the uninverted sequence; inversion is undone on the received side.
  assign rx_plain   = rx.rx_data ^ {DATA_W{inv}};
  assign diff       = rx_plain ^ pred_word;
  assign seed       = rx_plain[HIST_W-1:0] & order_mask(datawidth);
  assign sel_change = (datawidth != sel_q) || (inv != inv_q);
  assign locked     = (state == ST_LOCKED);

  prbs_par_predict #(.DATA_W(DATA_W)) u_predict (
    .sel       (datawidth),
    .hist      (hist),
    .pred_word (pred_word),
    .next_hist (pred_hist)
  );

  always_comb begin
    err_bits = '0;
    for (int i = 0; i < DATA_W; i++) err_bits = err_bits + ERR_W'(diff[i]);
  end

  always_comb begin
    state_nxt  = state;
    hist_nxt   = hist;
    good_nxt   = good_cnt;
    bad_nxt    = bad_cnt;
    count_word = 1'b0;
    if (channel_reset) begin
      state_nxt = ST_IDLE;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else if (sel_change) begin
      state_nxt = sel_valid(datawidth) ? ST_SEARCH : ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (sel_valid(datawidth)) state_nxt = ST_SEARCH;
        ST_SEARCH: if (rx.rx_valid) begin
          hist_nxt  = seed;
          good_nxt  = '0;
          state_nxt = ST_VERIFY;
        end
        ST_VERIFY: if (rx.rx_valid) begin
          if (diff == '0) begin
            hist_nxt = pred_hist;
            good_nxt = good_cnt + 1'b1;
            if (good_cnt == GOOD_W'(LOCK_WORDS - 1)) begin
              state_nxt = ST_LOCKED;
              bad_nxt   = '0;
            end
          end else begin
            hist_nxt = seed;
            good_nxt = '0;
          end
        end
        ST_LOCKED: if (rx.rx_valid) begin
          // Advance on predicted bits so a corrupted word cannot poison later predictions.
          count_word = 1'b1;
          hist_nxt   = pred_hist;
          if (diff != '0) begin
            bad_nxt = bad_cnt + 1'b1;
            if (bad_cnt == BAD_W'(UNLOCK_WORDS - 1)) state_nxt = ST_SEARCH;
          end else begin
            bad_nxt = '0;
          end
        end
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // NOTE: sequential state uses '<=' only; the history is plain flops, so it takes the reset too.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      hist        <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      sel_q       <= '0;
      inv_q       <= 1'b0;
      sel_invalid <= 1'b0;
      word_err    <= 1'b0;
      bit_count   <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      hist        <= hist_nxt;
      good_cnt    <= good_nxt;
      bad_cnt     <= bad_nxt;
      sel_q       <= datawidth;
      inv_q       <= inv;
      sel_invalid <= !sel_valid(datawidth);
      word_err    <= count_word && (diff != '0);
      if (channel_reset) begin
        bit_count <= '0;
        err_count <= '0;
      end else if (count_word) begin
        bit_count <= sat_add(bit_count, CNT_W'(DATA_W));
        err_count <= sat_add(err_count, CNT_W'(err_bits));
      end
    end
  end

endmodule
